aes_key_expand: RTL
===================

Name: aes_key_expand

Overview:
- Upstream neighbour of the 128-bit-block AES round datapath: supplies one 128-bit round key per cycle, which the datapath consumes on its roundKey input.
- Expands a 128/192/256-bit cipher key into a word schedule buffer, one word per cycle.
- Then streams round keys 0..Nr (encrypt) or Nr..0 (decrypt) at one key per cycle.
- Asserts keyLast with the final key; that flag drives the datapath's done input.

Parameters:
- MAXWORDS, 60, schedule buffer depth in 32-bit words (4*(14+1)).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  begin expansion; sampled only in IDLE or DONE
- dir  in  1  0 = forward round-key order (encrypt), 1 = reverse order (decrypt); latched on start
- keySize  in  2  0 = 128, 1 = 192, 2 = 256, 3 = treated as 128; latched on start
- key  in  256  cipher key, word 0 in [255:224]; 128-bit keys use [255:128], 192-bit keys use [255:64]; latched on start
- roundKey  out  128  current round key, word 4r in [127:96] through word 4r+3 in [31:0]
- keyValid  out  1  roundKey carries a streamed key this cycle
- keyLast  out  1  final round key of the sequence (wired to the datapath's done input)
- ready  out  1  expansion complete; first key appears the following cycle
- busy  out  1  high in LOAD, EXPAND and STREAM

Behaviour:
- Reset values: roundKey = 0, keyValid = 0, keyLast = 0, ready = 0, busy = 0, state = IDLE, word index = 0, round index = 0.
- Derived values: Nk = 4/6/8, Nr = Nk + 6, total words W = 4*(Nr+1) = 44/52/60.
- IDLE / DONE + start: latch key, keySize and dir; go to LOAD.
- LOAD (1 cycle): write words 0..Nk-1 into the buffer; set i = Nk; go to EXPAND.
- EXPAND (W-Nk cycles: 40/46/52): each cycle write w[i] = w[i-Nk] ^ t, where:
  - t = SubWord(RotWord(w[i-1])) ^ Rcon[i/Nk] when i mod Nk == 0;
  - t = SubWord(w[i-1]) when Nk == 8 and i mod 8 == 4;
  - otherwise t = w[i-1].
  - Rcon[j] is {rc_j, 24'h0} with rc = 01,02,04,08,10,20,40,80,1b,36.
  - i and Nk come from internal counters only; no divider. Keep a mod-Nk counter and an Rcon index register.
  - On the cycle writing w[W-1]: pulse ready, set r = 0 (dir=0) or r = Nr (dir=1), go to STREAM.
- STREAM (Nr+1 cycles):
  - roundKey = {w[4r], w[4r+1], w[4r+2], w[4r+3]}, registered; keyValid = 1.
  - r increments (dir=0) or decrements (dir=1) each cycle; no stall.
  - keyLast = 1 on the key with r = Nr (dir=0) or r = 0 (dir=1).
  - Then go to DONE.
- DONE:
  - keyValid = 0, keyLast held at 1, roundKey held at the last key. The datapath keeps using them in its final combinational output.
  - start restarts from LOAD.
- start while busy: ignored; latched values unchanged.
- reset mid-operation: next cycle IDLE, all outputs at reset values. Buffer contents are don't-care.
- Total latency: start edge to first keyValid = 1 + (W-Nk) + 1 cycles = 42/48/54.
- Buffer: MAXWORDS x 32 registers, one write port. Reads are w[i-1] and w[i-Nk] during EXPAND, and four words at 4r during STREAM.

Decomposition:
- Package aes_pkg holds:
  - keysize_t enum (K128, K192, K256);
  - Nk/Nr lookup functions;
  - 10-entry Rcon constant table;
  - keyexp state enum (IDLE, LOAD, EXPAND, STREAM, DONE).
- One sub-module, aes_subword: a 32-bit SubWord, four forward S-box lookups, purely combinational.
  - Only one instance; it is shared by the RotWord and plain SubWord paths via a mux on its input.

Test Plan:
- FIPS-197 A.1 key 2b7e1516 28aed2a6 abf71588 09cf4f3c, dir=0 -> first valid 42 cycles after start.
  - key0 = the cipher key; key1 = a0fafe17 88542cb1 23a33939 2a6c7605.
  - key10 = d014f9a8 c9ee2589 e13f0cc8 b6630ca6 with keyLast=1, held in DONE.
- A.2 key 8e73b0f7 da0e6452 c810f32b 809079e5 62f8ead2 522c6b7b, keySize=1 -> 13 valid keys, w51 = 01002202 in key12[31:0], keyLast on key12.
- A.3 key 603deb10 15ca71be 2b73aef0 857d7781 1f352c07 3b6108d7 2d9810a3 0914dff4, keySize=2 -> 15 keys, w59 = 706c631e; exercises the i mod 8 == 4 SubWord path.
- A.1 key with dir=1 -> first streamed key = d014f9a8...b6630ca6, last = 2b7e1516...09cf4f3c with keyLast=1.
- start pulsed during EXPAND with a different key -> ignored, A.1 outputs unchanged; start in DONE -> clean restart with new latency 42.
- reset asserted mid-STREAM -> next cycle keyValid = 0, keyLast = 0, roundKey = 0, busy = 0; a later start yields correct keys.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared types, constants and lookup helpers for the AES key expansion block.
package aes_pkg;

    // Cipher key length selector, as carried on the keySize input.
    typedef enum logic [1:0] {
        K128 = 2'd0,
        K192 = 2'd1,
        K256 = 2'd2
    } keysize_t;

    // Key expansion sequencer states.
    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        EXPAND,
        STREAM,
        DONE
    } keyexp_state_t;

    // Round constants rc_1..rc_10. Entry 0 is used on the first i mod Nk == 0 word.
    localparam logic [7:0] RCON [10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    // Map the raw keySize code to a key length; the unused code 3 behaves as 128-bit.
    function automatic keysize_t decode_keysize(input logic [1:0] raw);
        return (raw == 2'd3) ? K128 : keysize_t'(raw);
    endfunction

    // Number of 32-bit words in the cipher key.
    function automatic logic [3:0] nk_of(input keysize_t ks);
        case (ks)
            K192:    return 4'd6;
            K256:    return 4'd8;
            default: return 4'd4;
        endcase
    endfunction

    // Number of cipher rounds; there are Nr+1 round keys.
    function automatic logic [3:0] nr_of(input keysize_t ks);
        return nk_of(ks) + 4'd6;
    endfunction

endpackage

// File: rtl/aes_subword.sv
// SubWord: four parallel forward S-box lookups on a 32-bit word, purely combinational.
module aes_subword (
    input  logic [31:0] din,
    output logic [31:0] dout
);

    // Forward S-box, entry 0 in the top byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Byte b lives at bits [8*(255-b) +: 8]; 255-b is simply ~b.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[{~b, 3'b000} +: 8];
    endfunction

    assign dout = {sbox(din[31:24]), sbox(din[23:16]), sbox(din[15:8]), sbox(din[7:0])};

endmodule

// File: rtl/aes_key_expand.sv
// AES key schedule: expands a 128/192/256-bit key into a word buffer, one word
// per cycle, then streams round keys 0..Nr (encrypt) or Nr..0 (decrypt).
module aes_key_expand #(
    parameter int MAXWORDS = 60
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         dir,
    input  logic [1:0]   keySize,
    input  logic [255:0] key,
    output logic [127:0] roundKey,
    output logic         keyValid,
    output logic         keyLast,
    output logic         ready,
    output logic         busy
);

    import aes_pkg::*;

    localparam int AW = $clog2(MAXWORDS);

    keyexp_state_t state, state_next;

    logic [255:0]  key_r;
    keysize_t      ksize_r;
    logic          dir_r;
    logic [31:0]   w [MAXWORDS];
    logic [AW-1:0] wi;        // word index i being written during EXPAND
    logic [2:0]    imod;      // i mod Nk, tracked without a divider
    logic [3:0]    rc_idx;    // index into RCON for the next i mod Nk == 0 word
    logic [3:0]    r;         // round index being streamed

    logic [3:0]    nk, nr;
    logic [AW-1:0] last_word;
    logic [3:0]    first_round, last_round;
    logic [31:0]   prev_word, back_word, sub_in, sub_out, t_word, new_word;
    logic [AW-1:0] rbase;

    assign nk          = nk_of(ksize_r);
    assign nr          = nr_of(ksize_r);
    assign last_word   = AW'({nr, 2'b11});          // 4*(Nr+1)-1
    assign first_round = dir_r ? nr : 4'd0;
    assign last_round  = dir_r ? 4'd0 : nr;

    assign prev_word = w[wi - AW'(1)];
    assign back_word = w[wi - AW'(nk)];
    assign rbase     = AW'({r, 2'b00});

    // The single S-box instance serves both RotWord+SubWord and plain SubWord.
    assign sub_in = (imod == 3'd0) ? {prev_word[23:0], prev_word[31:24]} : prev_word;

    aes_subword u_subword (
        .din  (sub_in),
        .dout (sub_out)
    );

    // Select the temp word t for the word being generated this cycle.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        t_word = prev_word;
        if (imod == 3'd0)
            t_word = sub_out ^ {RCON[rc_idx], 24'h0};
        else if (nk == 4'd8 && imod == 3'd4)
            t_word = sub_out;
    end

    assign new_word = back_word ^ t_word;

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: if (start) state_next = LOAD;
            LOAD:       state_next = EXPAND;
            EXPAND:     if (wi == last_word) state_next = STREAM;
            STREAM:     if (r == last_round) state_next = DONE;
            default:    state_next = IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        busy = (state == LOAD) || (state == EXPAND) || (state == STREAM);
    end

    // Schedule buffer writes: key words in LOAD, one expanded word per EXPAND cycle.
    always_ff @(posedge clk) begin
        // NOTE: the buffer has no reset; every word is written before it is ever read.
        if (state == LOAD) begin
            for (int j = 0; j < 8; j++)
                w[j] <= key_r[255 - 32*j -: 32];
        end else if (state == EXPAND) begin
            w[wi] <= new_word;
        end
    end

    // Latched request, expansion counters and registered round-key outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            key_r    <= '0;
            ksize_r  <= K128;
            dir_r    <= 1'b0;
            wi       <= '0;
            imod     <= '0;
            rc_idx   <= '0;
            r        <= '0;
            roundKey <= '0;
            keyValid <= 1'b0;
            keyLast  <= 1'b0;
            ready    <= 1'b0;
        end else begin
            ready    <= 1'b0;
            keyValid <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        key_r   <= key;
                        ksize_r <= decode_keysize(keySize);
                        dir_r   <= dir;
                        keyLast <= 1'b0;
                    end
                end
                LOAD: begin
                    wi     <= AW'(nk);
                    imod   <= '0;
                    rc_idx <= '0;
                end
                EXPAND: begin
                    wi   <= wi + AW'(1);
                    imod <= ({1'b0, imod} == nk - 4'd1) ? 3'd0 : imod + 3'd1;
                    if (imod == 3'd0)
                        rc_idx <= rc_idx + 4'd1;
                    if (wi == last_word) begin
                        ready <= 1'b1;
                        r     <= first_round;
                    end
                end
                STREAM: begin
                    roundKey <= {w[rbase], w[rbase + AW'(1)], w[rbase + AW'(2)], w[rbase + AW'(3)]};
                    keyValid <= 1'b1;
                    keyLast  <= (r == last_round);
                    r        <= dir_r ? r - 4'd1 : r + 4'd1;
                end
                default: ;
            endcase
        end
    end

endmodule
